// File: rtl/dm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dm_ctrl
//  Description : Byte-lane data memory for the MIPS core. Supports byte/half/
//                word loads and stores inside a base-address window, a
//                request/response handshake with one-cycle registered read
//                latency, alignment/range error reporting and a clear
//                sequencer that zeroes the word array after every reset.
//                Optional store trace: define DM_TRACE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_ctrl #(
    parameter int          DEPTH     = 3072,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] C_LIMIT = 33'(DEPTH) << 2;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;

    logic [31:0]     mem_q [DEPTH];
    logic [31:0]     raw_q;

    logic            rsp_valid_q;
    logic            rsp_err_q;
    logic            load_q;
    logic [1:0]      size_q;
    logic [1:0]      lane_q;
    logic            uns_q;

    logic [31:0]     w_off;
    logic [1:0]      w_lane;
    logic [AW-1:0]   w_idx;
    logic            w_err;
    logic            w_accept;
    logic            w_store_ok;
    logic            w_load_ok;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata_rep;
    logic [31:0]     w_ext;

    // Address decode: offset into the window, word index and byte lane
    assign w_off  = req_addr - BASE_ADDR;
    assign w_lane = w_off[1:0];
    assign w_idx  = w_off[AW+1:2];

    assign req_ready = (state_q == S_RUN);
    assign busy      = (state_q == S_CLEAR);
    assign w_accept  = req_valid & req_ready;

    // Error classification: illegal size, misalignment, or outside window
    always_comb begin
        w_err = 1'b0;
        if (req_size == 2'd3)                        w_err = 1'b1;
        if ((req_size == 2'd1) && w_lane[0])         w_err = 1'b1;
        if ((req_size == 2'd2) && (w_lane != 2'd0))  w_err = 1'b1;
        if (req_addr < BASE_ADDR)                    w_err = 1'b1;
        if ({1'b0, w_off} >= C_LIMIT)                w_err = 1'b1;
    end

    assign w_store_ok = w_accept &  req_we & ~w_err;
    assign w_load_ok  = w_accept & ~req_we & ~w_err;

    // Byte enables and lane-replicated store data
    always_comb begin
        w_be        = 4'b0000;
        w_wdata_rep = req_wdata;
        case (req_size)
            2'd0: begin
                w_be        = 4'b0001 << w_lane;
                w_wdata_rep = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                w_be        = 4'b0011 << w_lane;
                w_wdata_rep = {2{req_wdata[15:0]}};
            end
            2'd2: begin
                w_be        = 4'b1111;
            end
            default: begin
                w_be        = 4'b0000;
            end
        endcase
    end

    // FSM state register and clear counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: walk the clear counter over every word, then run
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_CLEAR) begin
            if (cnt_q == AW'(DEPTH - 1)) begin
                state_d = S_RUN;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q + AW'(1);
            end
        end
    end

    // Word array: cleared by the sequencer, byte-masked stores in RUN.
    // The FSM drops to CLEAR asynchronously, so a store whose edge falls
    // inside reset never reaches the array.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else if (w_store_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    mem_q[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
                end
            end
        end
    end

    // Registered read of the addressed word on an accepted load
    always_ff @(posedge clk) begin
        if (w_load_ok) begin
            raw_q <= mem_q[w_idx];
        end
    end

    // Response control registers; reset drops any pending response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            load_q      <= 1'b0;
            size_q      <= 2'd0;
            lane_q      <= 2'd0;
            uns_q       <= 1'b0;
        end else begin
            rsp_valid_q <= w_accept;
            rsp_err_q   <= w_accept & w_err;
            load_q      <= w_load_ok;
            if (w_accept) begin
                size_q <= req_size;
                lane_q <= w_lane;
                uns_q  <= req_unsigned;
            end
        end
    end

    // Lane select and sign/zero extension of the registered word
    always_comb begin
        logic [7:0]  v_byte;
        logic [15:0] v_half;
        v_byte = raw_q[8*lane_q +: 8];
        v_half = lane_q[1] ? raw_q[31:16] : raw_q[15:0];
        case (size_q)
            2'd0:    w_ext = {{24{v_byte[7]  & ~uns_q}}, v_byte};
            2'd1:    w_ext = {{16{v_half[15] & ~uns_q}}, v_half};
            default: w_ext = raw_q;
        endcase
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = (rsp_valid_q & load_q) ? w_ext : 32'h0;

`ifdef DM_TRACE_EN
    logic [31:0] w_trace_word;

    // Merged word as it will read back after this store
    always_comb begin
        w_trace_word = mem_q[w_idx];
        for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
                w_trace_word[8*b +: 8] = w_wdata_rep[8*b +: 8];
            end
        end
    end

    // Print one trace line per committed store
    always_ff @(posedge clk) begin
        if (reset && w_store_ok) begin
            $display("@%08h: *%08h <= %08h", req_pc, {req_addr[31:2], 2'b00}, w_trace_word);
        end
    end
`else
    logic w_unused_pc;
    assign w_unused_pc = ^req_pc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_ctrl
//  Description : Self-checking bench for dm_ctrl (DEPTH=16, base 0x8000_0000)
//                with a byte-level reference model of the memory window.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_ctrl;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [DEPTH];

    dm_ctrl #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_err(input logic [1:0] size, input logic [31:0] addr);
        longint off;
        off = longint'(addr) - longint'(BASE);
        if (size == 2'd3) return 1'b1;
        if (off < 0 || off >= DEPTH * 4) return 1'b1;
        if (size == 2'd1 && (addr % 2) != 0) return 1'b1;
        if (size == 2'd2 && (addr % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] addr);
        int unsigned off, lane;
        logic [31:0] w, v;
        off  = addr - BASE;
        lane = off % 4;
        w    = model[off / 4];
        v    = 32'h0;
        if (size == 2'd0) begin
            v = (w >> (8 * lane)) & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (w >> (8 * lane)) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] data);
        int unsigned off, idx, lane, nbytes;
        logic [31:0] b;
        off    = addr - BASE;
        idx    = off / 4;
        lane   = off % 4;
        nbytes = 1 << size;
        for (int k = 0; k < int'(nbytes); k++) begin
            b = (data >> (8 * k)) & 32'hFF;
            model[idx] = (model[idx] & ~(32'hFF << (8 * (lane + k)))) | (b << (8 * (lane + k)));
        end
    endtask

    // One request, issued at a falling edge; its response is checked at the
    // next falling edge, so successive calls give back-to-back requests.
    task automatic req(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] data, input string tag);
        logic        e_err;
        logic [31:0] e_data;
        e_err  = ref_err(size, addr);
        e_data = 32'h0;
        if (!e_err) begin
            if (we) ref_store(size, addr, data);
            else    e_data = ref_load(size, uns, addr);
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = data;
        req_pc       = 32'h0040_0000 + $urandom_range(0, 255) * 4;
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, "/valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "/err"},   {31'd0, rsp_err},   {31'd0, e_err});
        chk({tag, "/rdata"}, rsp_rdata, e_data);
    endtask

    task automatic idle();
        req_valid = 1'b0;
        @(negedge clk);
        chk("idle/valid", {31'd0, rsp_valid}, 32'd0);
    endtask

    // Wait out the clear sequence after a reset release, counting busy cycles
    task automatic wait_clear(input string tag);
        int n, pulses;
        n = 0;
        pulses = 0;
        while (busy && n < 100) begin
            n++;
            chk({tag, "/ready"}, {31'd0, req_ready}, 32'd0);
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        req_valid = 1'b0;
        chk({tag, "/len"},    n, DEPTH);
        chk({tag, "/norsp"},  pulses, 0);
        chk({tag, "/rdy_on"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        reset        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        req_pc       = 32'h0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

        // Reset held for three cycles
        repeat (3) @(negedge clk);
        chk("rst/busy",  {31'd0, busy},      32'd1);
        chk("rst/ready", {31'd0, req_ready}, 32'd0);
        chk("rst/valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst/err",   {31'd0, rsp_err},   32'd0);
        chk("rst/rdata", rsp_rdata,          32'd0);

        // Release with a store held on the bus: it must be ignored while clearing
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd2;
        req_addr  = BASE;
        req_wdata = 32'hFFFF_FFFF;
        reset     = 1'b1;
        wait_clear("clear1");

        req(0, 2'd2, 0, BASE, 32'h0, "ld0");

        req(1, 2'd2, 0, BASE + 4, 32'hDEAD_BEEF, "sw4");
        req(1, 2'd0, 0, BASE + 5, 32'h0000_0012, "sb5");
        req(0, 2'd2, 0, BASE + 4, 32'h0, "lw4");

        req(1, 2'd2, 0, BASE, 32'h0000_80F0, "sw0");
        req(0, 2'd0, 0, BASE, 32'h0, "lb0");
        req(0, 2'd0, 1, BASE, 32'h0, "lbu0");
        req(0, 2'd1, 0, BASE, 32'h0, "lh0");
        req(0, 2'd1, 1, BASE, 32'h0, "lhu0");

        req(1, 2'd1, 0, BASE + 3, 32'h1234_5678, "sh3");
        req(0, 2'd2, 0, BASE + 2, 32'h0, "lw2");
        req(0, 2'd2, 0, BASE, 32'h0, "lw0_again");

        req(0, 2'd2, 0, BASE + DEPTH * 4, 32'h0, "over");
        req(0, 2'd2, 0, BASE - 4, 32'h0, "under");
        req(1, 2'd2, 0, BASE - 4, 32'h5555_5555, "under_st");
        req(0, 2'd3, 0, BASE, 32'h0, "size3");
        idle();

        // Back-to-back alternating store/load of one word
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) req(1, 2'd2, 0, BASE + 12, $urandom, "bb_st");
            else            req(0, 2'd2, 0, BASE + 12, 32'h0, "bb_ld");
        end

        // Randomized traffic, including addresses just outside the window
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
            end else begin
                req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)),
                    BASE - 8 + $urandom_range(0, DEPTH * 4 + 15),
                    $urandom, "rnd");
            end
        end

        // Reset mid-stream: pending response dropped, in-flight store lost
        req(1, 2'd2, 0, BASE + 8, 32'h1111_2222, "pre_rst");
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd2;
        req_addr  = BASE + 20;
        req_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #2;
        chk("mid/valid_before", {31'd0, rsp_valid}, 32'd1);
        req_addr  = BASE + 24;
        req_wdata = 32'hBAAD_F00D;
        #1;
        reset = 1'b0;
        #1;
        chk("mid/valid_drop", {31'd0, rsp_valid}, 32'd0);
        chk("mid/busy",       {31'd0, busy},      32'd1);
        chk("mid/ready",      {31'd0, req_ready}, 32'd0);
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_clear("clear2");

        for (int i = 0; i < DEPTH; i++) begin
            req(0, 2'd2, 0, BASE + 4 * i, 32'h0, "post_clr");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dm_ctrl.md
Name: dm_ctrl

Overview:
- Parametrised, byte-lane data memory for the single-cycle/multicycle MIPS core.
- Sits between the datapath load/store unit and an internal word array.
- Adds sub-word loads/stores, a base address window, and a request/response handshake with one-cycle registered read latency.
- Adds alignment and range error reporting and a hardware clear sequencer that zeroes the array after reset.

Parameters:
- DEPTH, 3072: number of 32-bit words; any value ≥ 2.
- BASE_ADDR, 32'h0000_0000: byte address mapped to word 0; must be word aligned.
- AW, $clog2(DEPTH): word index width (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present this cycle.
- req_ready  output  1  block accepts a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_unsigned  input  1  zero-extend sub-word loads (lbu/lhu); ignored for stores and word loads.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; byte/half taken from the low lanes.
- req_pc  input  32  PC of the issuing instruction (trace only).
- rsp_valid  output  1  response strobe, exactly one per accepted request.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  request was misaligned, out of range, or had size 3.
- busy  output  1  clear sequence in progress.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to CLEAR and the clear counter goes to 0.
  - Output values: rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=1, req_ready=0.
- CLEAR state:
  - Writes 0 to word[cnt] and increments cnt each cycle.
  - After writing word DEPTH-1, moves to RUN. Clear takes exactly DEPTH cycles after reset release.
  - busy=1 and req_ready=0 throughout CLEAR.
- RUN state: busy=0, req_ready=1. A request is accepted on any edge where req_valid & req_ready.
- Offset and index:
  - off = req_addr - BASE_ADDR.
  - Word index = off[AW+1:2]; lane = off[1:0].
- Error, evaluated in the accept cycle, is any of:
  - size 3;
  - half with lane[0]=1;
  - word with lane≠0;
  - req_addr < BASE_ADDR;
  - off ≥ DEPTH*4.
- On error:
  - No array write.
  - Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Store:
  - Byte enables are 0001<<lane (byte), 0011<<lane (half), or 1111 (word).
  - Write data is replicated across lanes; only enabled bytes change.
  - Next cycle: rsp_valid=1, rsp_err=0, rsp_rdata=0.
- Load:
  - The word is read at the accept edge and registered.
  - Next cycle: rsp_valid=1, rsp_rdata = selected byte/half shifted to bit 0, sign- or zero-extended per req_unsigned. Word loads are returned unmodified.
- Latency and throughput:
  - Response latency is exactly 1 cycle; back-to-back requests every cycle are allowed.
  - rsp_valid is a one-cycle pulse per request. No response backpressure.
- Ordering:
  - A store at cycle N followed by a load of the same word at N+1 returns the stored data, because the write is committed at edge N.
  - Write-first ordering applies only across cycles; one request per cycle makes same-cycle read/write impossible.
- Reset mid-operation:
  - A pending response is dropped (rsp_valid=0).
  - An in-flight store that has not reached its edge has no effect.
  - The array is re-cleared.
- req_valid during CLEAR is ignored: no response and no write.

Optional Feature:
- Macro DM_TRACE_EN.
- Defined: on every accepted, error-free store, simulation prints "@<pc>: *<addr> <= <data>" (hex, 8 digits).
  - addr is the word-aligned byte address.
  - data is the full merged 32-bit word after the write.
- Undefined: no $display and no trace logic; req_pc is left unused.

Test Plan:
1. Reset low 3 cycles, then release with DEPTH=16 → busy=1 for exactly 16 cycles, then req_ready=1; a load of 0x0 returns rsp_rdata=0, rsp_err=0.
2. Store word 0x8000_0004 ← 0xDEADBEEF with BASE_ADDR=0x8000_0000, then store byte 0x8000_0005 ← 0x12 → load word returns 0xDEAD12EF; trace line "@<pc>: *80000004 <= dead12ef" when DM_TRACE_EN is defined.
3. Word 0x0 = 0x0000_80F0:
   - lb 0x0 → 0xFFFF_FFF0.
   - lbu 0x0 → 0x0000_00F0.
   - lh 0x0 → 0xFFFF_80F0.
   - lhu 0x0 → 0x0000_80F0.
4. Half store to 0x3 and word load from 0x2 → rsp_err=1, rsp_rdata=0; a subsequent load of word 0 shows it unchanged.
5. Address BASE_ADDR+DEPTH*4 and address BASE_ADDR-4 → rsp_err=1; size=3 → rsp_err=1.
6. Stream of 8 back-to-back requests (alternating store/load of the same word) → 8 rsp_valid pulses on consecutive cycles, each load returning the preceding store's data; reset asserted mid-stream → rsp_valid drops immediately and busy rises.
